botao_req: RTL and testbench

Pedestrian-button conditioner sitting directly upstream of the semaforo controller. Takes the raw, asynchronous, bouncing push-button and synchronises and debounces it. Converts each clean press into one request toward semaforo's bt input, held until semaforo acknowledges. Also keeps a saturating count of accepted presses for debug/display.

---
 rtl/botao_req.sv | 123 ++++++++++++
 tb/tb_botao_req.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/botao_req.sv
// Pedestrian button conditioner: 2-flop sync, DEB_CYCLES debounce, one request per press, saturating press counter.
// Request visible DEB_CYCLES+2 edges after bt_raw rises; BOTAO_PULSE_EN selects 1-cycle pulse output instead of level/ack handshake.
module botao_req #(
    parameter int DEB_CYCLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bt_raw,
    input  logic             ack,
    output logic             bt,
    output logic             pending,
    output logic [CNT_W-1:0] press_cnt
);

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_RISE_CHK = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_FALL_CHK = 2'd3;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [7:0]       deb_cnt_q, deb_cnt_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             press_evt;
    logic             cnt_sat;

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        press_evt = 1'b0;
        case (state_q)
            S_LOW: begin
                if (sync2_q) begin
                    state_d   = S_RISE_CHK;
                    deb_cnt_d = 8'd1;
                end
            end
            S_RISE_CHK: begin
                if (!sync2_q) begin
                    state_d   = S_LOW;
                    deb_cnt_d = 8'd0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = S_HIGH;
                    deb_cnt_d = 8'd0;
                    press_evt = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 8'd1;
                end
            end
            S_HIGH: begin
                if (!sync2_q) begin
                    state_d   = S_FALL_CHK;
                    deb_cnt_d = 8'd1;
                end
            end
            default: begin
                // A bounce back high during release returns to S_HIGH without a new event
                if (sync2_q) begin
                    state_d   = S_HIGH;
                    deb_cnt_d = 8'd0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = S_LOW;
                    deb_cnt_d = 8'd0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 8'd1;
                end
            end
        endcase
    end

    assign cnt_sat = &press_cnt_q;

`ifdef BOTAO_PULSE_EN
    always_comb begin
        pending_d   = press_evt;
        press_cnt_d = press_cnt_q;
        if (press_evt && !cnt_sat) begin
            press_cnt_d = press_cnt_q + CNT_W'(1);
        end
    end
`else
    always_comb begin
        pending_d   = pending_q;
        press_cnt_d = press_cnt_q;
        if (press_evt) begin
            // A press coinciding with ack starts a fresh request rather than being dropped
            pending_d = 1'b1;
            if ((!pending_q || ack) && !cnt_sat) begin
                press_cnt_d = press_cnt_q + CNT_W'(1);
            end
        end else if (ack) begin
            pending_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= S_LOW;
            deb_cnt_q   <= 8'd0;
            pending_q   <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            sync1_q     <= bt_raw;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            pending_q   <= pending_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign bt        = pending_q;
    assign pending   = pending_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_botao_req.sv
// Vector-table plus scoreboard bench for botao_req; define BOTAO_PULSE_EN to exercise pulse mode.
module tb_botao_req;

    logic       clk;
    logic       rst;
    logic       bt_raw;
    logic       ack;
    logic       bt;
    logic       pending;
    logic [7:0] press_cnt;

    botao_req #(.DEB_CYCLES(3), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bt_raw    (bt_raw),
        .ack       (ack),
        .bt        (bt),
        .pending   (pending),
        .press_cnt (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       raw;
        logic       ak;
        logic       chk;
        logic       exp_bt;
        logic [7:0] exp_cnt;
    } vec_t;

    typedef struct {
        logic       exp_bt;
        logic [7:0] exp_cnt;
        int         id;
    } exp_t;

    vec_t tbl[160];
    int   n_vec;
    exp_t sb[$];
    int   total;
    int   bad;

    task automatic add(input logic r, input logic raw, input logic ak,
                       input logic eb, input int ec, input int reps);
        for (int i = 0; i < reps; i++) begin
            tbl[n_vec] = '{r, raw, ak, 1'b1, eb, 8'(ec)};
            n_vec++;
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        exp_t e;
        rst    = v.r;
        bt_raw = v.raw;
        ack    = v.ak;
        if (v.chk) sb.push_back('{v.exp_bt, v.exp_cnt, id});
        @(posedge clk);
        #1;
        if (v.chk) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty id=%0d", id);
            end else begin
                e = sb.pop_front();
                if (bt !== e.exp_bt || pending !== e.exp_bt || press_cnt !== e.exp_cnt) begin
                    bad++;
                    $display("FAIL vec%0d: got bt=%b pending=%b cnt=%0d, want bt=%b pending=%b cnt=%0d",
                             e.id, bt, pending, press_cnt, e.exp_bt, e.exp_bt, e.exp_cnt);
                end
            end
        end
    endtask

    initial begin
        vec_t v;
        int   exp_c;
        total  = 0;
        bad    = 0;
        n_vec  = 0;
        rst    = 1'b0;
        bt_raw = 1'b0;
        ack    = 1'b0;

`ifdef BOTAO_PULSE_EN
        add(0, 0, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 4);
        add(1, 1, 1, 1, 1, 1);
        add(1, 1, 1, 0, 1, 1);
        add(1, 1, 0, 0, 1, 2);
        add(1, 0, 0, 0, 1, 5);
        add(1, 1, 0, 0, 1, 4);
        add(1, 1, 0, 1, 2, 1);
        add(1, 1, 0, 0, 2, 2);
        add(1, 0, 1, 0, 2, 5);
`else
        // reset with button held, then first press
        add(0, 1, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 4);
        add(1, 1, 0, 1, 1, 1);
        add(1, 0, 1, 0, 1, 1);
        add(1, 0, 0, 0, 1, 4);
        // 2-cycle glitch
        add(1, 1, 0, 0, 1, 2);
        add(1, 0, 0, 0, 1, 4);
        // press, second press dropped while pending, then ack
        add(1, 1, 0, 0, 1, 4);
        add(1, 1, 0, 1, 2, 1);
        add(1, 0, 0, 1, 2, 5);
        add(1, 1, 0, 1, 2, 5);
        add(1, 1, 1, 0, 2, 1);
        add(1, 1, 0, 0, 2, 1);
        add(1, 0, 0, 0, 2, 5);
        // ack coinciding with a new press
        add(1, 1, 0, 0, 2, 4);
        add(1, 1, 0, 1, 3, 1);
        add(1, 0, 0, 1, 3, 5);
        add(1, 1, 0, 1, 3, 4);
        add(1, 1, 1, 1, 4, 1);
        add(1, 1, 0, 1, 4, 1);
        add(1, 1, 1, 0, 4, 1);
        add(1, 0, 0, 0, 4, 5);
        // bouncy press and bouncy release
        add(1, 1, 0, 0, 4, 1);
        add(1, 0, 0, 0, 4, 1);
        add(1, 1, 0, 0, 4, 4);
        add(1, 1, 0, 1, 5, 1);
        add(1, 1, 1, 0, 5, 1);
        add(1, 0, 0, 0, 5, 1);
        add(1, 1, 0, 0, 5, 1);
        add(1, 0, 0, 0, 5, 6);
        // reset mid-debounce, then reset while pending
        add(1, 1, 0, 0, 5, 3);
        add(0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 4);
        add(1, 1, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1);
`endif

        for (int i = 0; i < n_vec; i++) begin
            apply(tbl[i], i);
        end

        // saturation: 300 press/ack pairs from a fresh reset
        apply('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0}, 1000);
        for (int p = 1; p <= 300; p++) begin
            exp_c = (p > 255) ? 255 : p;
            for (int c = 0; c < 4; c++) begin
                v = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
                apply(v, 2000 + p);
            end
            v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'(exp_c)};
            apply(v, 2000 + p);
            v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'(exp_c)};
            apply(v, 2000 + p);
            for (int c = 0; c < 4; c++) begin
                v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
                apply(v, 2000 + p);
            end
        end

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
